// File: rtl/instr_load_ctrl.sv
// instr_load_ctrl: boot loader sequencer and instruction BRAM port arbiter
module instr_load_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ld_valid,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic [ADDR_W-1:0] i_ld_addr,
  output logic              o_ld_ready,
  input  logic              i_ld_empty,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic              i_reload,
  output logic              o_bram_we,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [DATA_W-1:0] o_bram_wdata,
  output logic              o_cpu_rst,
  output logic              o_load_done,
  output logic [ADDR_W:0]   o_word_cnt,
  output logic              o_err_addr
);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(IDLE_TIMEOUT - 1);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  typedef enum logic [1:0] {S_WAIT, S_LOAD, S_DRAIN, S_RUN} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic ready_q, we_q, cpu_rst_q, done_q, acc;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  // next state: accepted beats restart the idle timer, the full beat drains at once, reload only from run
  always_comb begin
    acc = i_ld_valid && ready_q;
    state_d = state_q;
    cnt_d = cnt_q;
    tmr_d = tmr_q;
    err_d = err_q;
    if (acc) begin
      cnt_d = (cnt_q == DEPTH) ? cnt_q : cnt_q + 1'b1;
      tmr_d = '0;
      err_d = err_q | (i_ld_addr != cnt_q[ADDR_W-1:0]);
      state_d = (cnt_d == DEPTH) ? S_DRAIN : S_LOAD;
    end else begin
      case (state_q)
        S_LOAD: begin
          tmr_d = (tmr_q >= TMAX) ? tmr_q : tmr_q + 1'b1;
          state_d = (tmr_d >= TMAX) ? S_DRAIN : S_LOAD;
        end
        S_DRAIN: state_d = (i_ld_empty && !we_q) ? S_RUN : S_DRAIN;
        S_RUN: if (i_reload) begin
          state_d = S_WAIT;
          cnt_d = '0;
          tmr_d = '0;
          err_d = 1'b0;
        end
        default: ;
      endcase
    end
  end
  // state and registered outputs; ready is precomputed so a full beat drops it on the same edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_WAIT;
      cnt_q <= '0;
      tmr_q <= '0;
      err_q <= 1'b0;
      ready_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cpu_rst_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
      err_q <= err_d;
      ready_q <= (state_d != S_RUN) && (cnt_d < DEPTH);
      we_q <= acc;
      if (acc) begin
        addr_q <= i_ld_addr;
        wdata_q <= i_ld_data;
      end
      cpu_rst_q <= state_d != S_RUN;
      done_q <= state_d == S_RUN;
    end
  end
  // CPU fetch owns the address port while running, with no added latency
  always_comb begin
    o_bram_addr = (state_q == S_RUN) ? i_cpu_addr : addr_q;
  end
  assign o_ld_ready = ready_q;
  assign o_bram_we = we_q;
  assign o_bram_wdata = wdata_q;
  assign o_cpu_rst = cpu_rst_q;
  assign o_load_done = done_q;
  assign o_word_cnt = cnt_q;
  assign o_err_addr = err_q;
endmodule

// File: tb/tb_instr_load_ctrl.sv
// tb_instr_load_ctrl: directed checks of load sequencing, handoff, reload and reset
module tb_instr_load_ctrl;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 16;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_ld_valid = 1'b0;
  logic [DW-1:0] i_ld_data = '0;
  logic [AW-1:0] i_ld_addr = '0;
  logic o_ld_ready;
  logic i_ld_empty = 1'b1;
  logic [AW-1:0] i_cpu_addr = '0;
  logic i_reload = 1'b0;
  logic o_bram_we;
  logic [AW-1:0] o_bram_addr;
  logic [DW-1:0] o_bram_wdata;
  logic o_cpu_rst;
  logic o_load_done;
  logic [AW:0] o_word_cnt;
  logic o_err_addr;
  int checks = 0;
  int errors = 0;
  int n;
  instr_load_ctrl #(.ADDR_W(AW), .DATA_W(DW), .IDLE_TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ld_valid(i_ld_valid), .i_ld_data(i_ld_data),
    .i_ld_addr(i_ld_addr), .o_ld_ready(o_ld_ready), .i_ld_empty(i_ld_empty),
    .i_cpu_addr(i_cpu_addr), .i_reload(i_reload), .o_bram_we(o_bram_we),
    .o_bram_addr(o_bram_addr), .o_bram_wdata(o_bram_wdata), .o_cpu_rst(o_cpu_rst),
    .o_load_done(o_load_done), .o_word_cnt(o_word_cnt), .o_err_addr(o_err_addr)
  );
  always #5 i_clk = ~i_clk;
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_ld_valid = 1'b1;
    i_ld_addr = a;
    i_ld_data = d;
    tick();
    i_ld_valid = 1'b0;
  endtask
  task automatic wait_run(output int cyc);
    cyc = 0;
    while (o_cpu_rst === 1'b1 && cyc < 200) begin
      tick();
      cyc++;
      chk("cpu_rst_vs_done", o_load_done, !o_cpu_rst);
    end
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, "_we"}, o_bram_we, 0);
    chk({tag, "_addr"}, o_bram_addr, 0);
    chk({tag, "_wdata"}, o_bram_wdata, 0);
    chk({tag, "_cpu_rst"}, o_cpu_rst, 1);
    chk({tag, "_done"}, o_load_done, 0);
    chk({tag, "_cnt"}, o_word_cnt, 0);
    chk({tag, "_err"}, o_err_addr, 0);
    chk({tag, "_ready"}, o_ld_ready, 0);
  endtask
  initial begin
    tick();
    tick();
    reset_vals("rst");
    i_rst = 1'b0;
    tick();
    chk("wait_ready", o_ld_ready, 1);
    for (int i = 0; i < 4; i++) begin
      beat(AW'(i), DW'((i + 1) * 16'h1111));
      chk("ld4_we", o_bram_we, 1);
      chk("ld4_addr", o_bram_addr, i);
      chk("ld4_wdata", o_bram_wdata, (i + 1) * 16'h1111);
      chk("ld4_cnt", o_word_cnt, i + 1);
    end
    wait_run(n);
    chk("ld4_run_lat", n, TO);
    chk("ld4_done", o_load_done, 1);
    chk("ld4_err", o_err_addr, 0);
    chk("ld4_cnt_final", o_word_cnt, 4);
    chk("ld4_we_idle", o_bram_we, 0);
    i_cpu_addr = 8'h02;
    #1;
    chk("run_fetch_02", o_bram_addr, 8'h02);
    chk("run_we", o_bram_we, 0);
    chk("run_ready", o_ld_ready, 0);
    i_cpu_addr = 8'h7f;
    #1;
    chk("run_fetch_7f", o_bram_addr, 8'h7f);
    i_reload = 1'b1;
    tick();
    i_reload = 1'b0;
    chk("reload_cpu_rst", o_cpu_rst, 1);
    chk("reload_done", o_load_done, 0);
    chk("reload_cnt", o_word_cnt, 0);
    chk("reload_ready", o_ld_ready, 1);
    beat(8'd0, 16'h00a0);
    chk("seq_err0", o_err_addr, 0);
    beat(8'd1, 16'h00a1);
    chk("seq_err1", o_err_addr, 0);
    beat(8'd5, 16'h00a5);
    chk("seq_err5", o_err_addr, 1);
    chk("seq_we5", o_bram_we, 1);
    chk("seq_addr5", o_bram_addr, 5);
    chk("seq_wdata5", o_bram_wdata, 16'h00a5);
    wait_run(n);
    chk("seq_run_lat", n, TO);
    chk("seq_err_sticky", o_err_addr, 1);
    chk("seq_cnt", o_word_cnt, 3);
    i_reload = 1'b1;
    tick();
    i_reload = 1'b0;
    chk("reload_err_clr", o_err_addr, 0);
    i_ld_empty = 1'b0;
    for (int i = 0; i < 256; i++) beat(AW'(i), DW'(i) ^ 16'hbeef);
    chk("full_cnt", o_word_cnt, 256);
    chk("full_ready", o_ld_ready, 0);
    chk("full_we", o_bram_we, 1);
    chk("full_addr", o_bram_addr, 8'hff);
    chk("full_wdata", o_bram_wdata, 16'h00ff ^ 16'hbeef);
    i_ld_valid = 1'b1;
    i_ld_addr = 8'h00;
    i_ld_data = 16'hdead;
    tick();
    tick();
    tick();
    i_ld_valid = 1'b0;
    chk("full_257_cnt", o_word_cnt, 256);
    chk("full_257_we", o_bram_we, 0);
    chk("full_257_wdata", o_bram_wdata, 16'h00ff ^ 16'hbeef);
    chk("full_hold_rst", o_cpu_rst, 1);
    i_ld_empty = 1'b1;
    tick();
    chk("full_run_now", o_cpu_rst, 0);
    chk("full_run_done", o_load_done, 1);
    i_reload = 1'b1;
    tick();
    i_reload = 1'b0;
    i_ld_empty = 1'b0;
    beat(8'd0, 16'h0c00);
    for (int i = 0; i < TO + 4; i++) tick();
    chk("to_drain_rst", o_cpu_rst, 1);
    chk("to_drain_done", o_load_done, 0);
    chk("to_drain_ready", o_ld_ready, 1);
    beat(8'd1, 16'h0c01);
    chk("to_again_cnt", o_word_cnt, 2);
    chk("to_again_we", o_bram_we, 1);
    chk("to_again_rst", o_cpu_rst, 1);
    i_ld_empty = 1'b1;
    wait_run(n);
    chk("to_again_lat", n, TO);
    i_reload = 1'b1;
    i_reload = 1'b1;
    tick();
    i_reload = 1'b0;
    beat(8'd0, 16'h0d00);
    beat(8'd1, 16'h0d01);
    i_ld_valid = 1'b1;
    i_ld_addr = 8'd2;
    i_ld_data = 16'h0d02;
    i_rst = 1'b1;
    tick();
    i_ld_valid = 1'b0;
    reset_vals("midrst");
    i_rst = 1'b0;
    tick();
    beat(8'd0, 16'h0e00);
    wait_run(n);
    chk("post_rst_lat", n, TO);
    i_rst = 1'b1;
    i_reload = 1'b1;
    tick();
    i_reload = 1'b0;
    reset_vals("rst_reload");
    i_rst = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
